// File: rtl/elastic_pipeline_reg_pkg.sv
// Shared definitions for the elastic pipeline stage: state encodings and the
// MEM/WB payload layout packed into the stage data bus.
package elastic_pipeline_reg_pkg;

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_FULL  = 2'd1;
  localparam logic [1:0] ST_SKID  = 2'd2;

  // MEM/WB packing, MSB first: reg_we, wb_sel, four 32-bit data words, rd.
  typedef struct packed {
    logic             reg_we;
    logic [1:0]       wb_sel;
    logic [3:0][31:0] data;
    logic [4:0]       rd;
  } memwb_t;

  localparam int MEMWB_WIDTH   = $bits(memwb_t);
  localparam int MEMWB_RD_LSB  = 0;
  localparam int MEMWB_RD_W    = 5;
  localparam int MEMWB_DAT_LSB = 5;
  localparam int MEMWB_DAT_W   = 128;
  localparam int MEMWB_SEL_LSB = 133;
  localparam int MEMWB_SEL_W   = 2;
  localparam int MEMWB_WE_LSB  = 135;

  function automatic logic [1:0] occupancy_of(input logic [1:0] state);
    case (state)
      ST_FULL: occupancy_of = 2'd1;
      ST_SKID: occupancy_of = 2'd2;
      default: occupancy_of = 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/elastic_pipeline_reg_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             inc,
  input  logic             clear,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge CLK) begin
    if (RESET || clear) begin
      count <= '0;
    end else if (inc && (count != {WIDTH{1'b1}})) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/elastic_pipeline_reg.sv
// Elastic pipeline stage register: valid/ready handshake with a 2-entry skid buffer,
// global stall, flush and a saturating stall-cycle counter.
module elastic_pipeline_reg
  import elastic_pipeline_reg_pkg::*;
#(
  parameter int DATA_WIDTH    = MEMWB_WIDTH,
  parameter int CNT_WIDTH     = 16,
  parameter bit ZERO_ON_FLUSH = 1'b1
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  FLUSH,
  input  logic                  STALL,
  input  logic                  IN_VALID,
  output logic                  IN_READY,
  input  logic [DATA_WIDTH-1:0] IN_DATA,
  output logic                  OUT_VALID,
  input  logic                  OUT_READY,
  output logic [DATA_WIDTH-1:0] OUT_DATA,
  output logic [1:0]            OCCUPANCY,
  output logic [CNT_WIDTH-1:0]  STALL_COUNT
);

  logic [1:0]            state_reg, state_next;
  logic [DATA_WIDTH-1:0] main_reg, main_next;
  logic [DATA_WIDTH-1:0] skid_reg, skid_next;
  logic                  in_fire, out_fire;

  assign IN_READY  = (state_reg != ST_SKID) && !STALL && !FLUSH;
  assign OUT_VALID = (state_reg != ST_EMPTY);
  assign OUT_DATA  = main_reg;
  assign OCCUPANCY = occupancy_of(state_reg);

  assign in_fire  = IN_VALID && IN_READY;
  assign out_fire = OUT_VALID && OUT_READY && !STALL;

  always_comb begin
    state_next = state_reg;
    main_next  = main_reg;
    skid_next  = skid_reg;
    if (FLUSH) begin
      state_next = ST_EMPTY;
      if (ZERO_ON_FLUSH) begin
        main_next = '0;
        skid_next = '0;
      end
    end else if (!STALL) begin
      case (state_reg)
        ST_EMPTY: begin
          if (in_fire) begin
            state_next = ST_FULL;
            main_next  = IN_DATA;
          end
        end
        ST_FULL: begin
          if (in_fire && out_fire) begin
            main_next = IN_DATA;
          end else if (in_fire) begin
            state_next = ST_SKID;
            skid_next  = IN_DATA;
          end else if (out_fire) begin
            state_next = ST_EMPTY;
          end
        end
        ST_SKID: begin
          // IN_READY is low here, so only the drain into main can happen.
          if (out_fire) begin
            state_next = ST_FULL;
            main_next  = skid_reg;
          end
        end
        default: state_next = ST_EMPTY;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_reg <= ST_EMPTY;
      main_reg  <= '0;
      skid_reg  <= '0;
    end else begin
      state_reg <= state_next;
      main_reg  <= main_next;
      skid_reg  <= skid_next;
    end
  end

  sat_counter #(
    .WIDTH(CNT_WIDTH)
  ) u_stall_cnt (
    .CLK  (CLK),
    .RESET(RESET),
    .inc  (OUT_VALID && !out_fire),
    .clear(1'b0),
    .count(STALL_COUNT)
  );

endmodule

// File: tb/tb_elastic_pipeline_reg.sv
// Bench for elastic_pipeline_reg: queue model checked every cycle on two instances
// (16-bit and 4-bit stall counters) plus directed literal expectations.
module tb_elastic_pipeline_reg;

  localparam int DW = 136;

  logic          CLK = 1'b0;
  logic          RESET, FLUSH, STALL, IN_VALID, OUT_READY;
  logic [DW-1:0] IN_DATA;

  logic          in_ready_a, out_valid_a, in_ready_b, out_valid_b;
  logic [DW-1:0] out_data_a, out_data_b;
  logic [1:0]    occ_a, occ_b;
  logic [15:0]   cnt_a;
  logic [3:0]    cnt_b;

  elastic_pipeline_reg #(.DATA_WIDTH(DW), .CNT_WIDTH(16), .ZERO_ON_FLUSH(1'b1)) dut_a (
    .CLK(CLK), .RESET(RESET), .FLUSH(FLUSH), .STALL(STALL),
    .IN_VALID(IN_VALID), .IN_READY(in_ready_a), .IN_DATA(IN_DATA),
    .OUT_VALID(out_valid_a), .OUT_READY(OUT_READY), .OUT_DATA(out_data_a),
    .OCCUPANCY(occ_a), .STALL_COUNT(cnt_a)
  );

  elastic_pipeline_reg #(.DATA_WIDTH(DW), .CNT_WIDTH(4), .ZERO_ON_FLUSH(1'b1)) dut_b (
    .CLK(CLK), .RESET(RESET), .FLUSH(FLUSH), .STALL(STALL),
    .IN_VALID(IN_VALID), .IN_READY(in_ready_b), .IN_DATA(IN_DATA),
    .OUT_VALID(out_valid_b), .OUT_READY(OUT_READY), .OUT_DATA(out_data_b),
    .OCCUPANCY(occ_b), .STALL_COUNT(cnt_b)
  );

  always #5 CLK = ~CLK;

  // Model: a FIFO of held payloads (at most two) and two saturating counters.
  logic [DW-1:0] mq[$];
  int unsigned   m_cnt_a = 0;
  int unsigned   m_cnt_b = 0;
  bit            model_live = 1'b0;
  logic [DW-1:0] got[$];
  int            checks = 0;
  int            fails  = 0;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(posedge CLK) begin
    if (RESET) begin
      mq.delete();
      m_cnt_a = 0;
      m_cnt_b = 0;
      model_live = 1'b1;
    end else if (model_live) begin
      bit ov, ofire, ifire;
      ov    = mq.size() > 0;
      ofire = ov && OUT_READY && !STALL;
      ifire = IN_VALID && (mq.size() < 2) && !STALL && !FLUSH;
      if (ov && !ofire) begin
        if (m_cnt_a < 65535) m_cnt_a++;
        if (m_cnt_b < 15) m_cnt_b++;
      end
      if (FLUSH) begin
        mq.delete();
      end else begin
        if (ofire) void'(mq.pop_front());
        if (ifire) mq.push_back(IN_DATA);
      end
    end
  end

  always @(negedge CLK) begin
    if (model_live) begin
      bit exp_rdy;
      exp_rdy = (mq.size() < 2) && !STALL && !FLUSH;
      check("in_ready_a", DW'(in_ready_a), DW'(exp_rdy));
      check("in_ready_b", DW'(in_ready_b), DW'(exp_rdy));
      check("out_valid_a", DW'(out_valid_a), DW'(mq.size() > 0));
      check("out_valid_b", DW'(out_valid_b), DW'(mq.size() > 0));
      check("occupancy_a", DW'(occ_a), DW'(mq.size()));
      check("occupancy_b", DW'(occ_b), DW'(mq.size()));
      check("stall_count_a", DW'(cnt_a), DW'(m_cnt_a));
      check("stall_count_b", DW'(cnt_b), DW'(m_cnt_b));
      if (mq.size() > 0) begin
        check("out_data_a", out_data_a, mq[0]);
        check("out_data_b", out_data_b, mq[0]);
      end
      if (out_valid_a && OUT_READY && !STALL) begin
        got.push_back(out_data_a);
        $display("xfer out data=%0h occ=%0d stall_count=%0d", out_data_a, occ_a, cnt_a);
      end
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic send(input logic [DW-1:0] d);
    IN_VALID = 1'b1;
    IN_DATA  = d;
    tick();
  endtask

  initial begin
    logic [DW-1:0] ones;
    logic [DW-1:0] exp_list[$];
    int unsigned   c0;

    RESET = 1'b1; FLUSH = 1'b0; STALL = 1'b0;
    IN_VALID = 1'b1; IN_DATA = DW'(8'h77); OUT_READY = 1'b0;

    // Reset held two cycles with IN_VALID high: nothing captured.
    tick(); tick();
    RESET = 1'b0; IN_VALID = 1'b0;
    check("rst_out_valid", DW'(out_valid_a), '0);
    check("rst_occupancy", DW'(occ_a), '0);
    check("rst_stall_count", DW'(cnt_a), '0);
    check("rst_out_data", out_data_a, '0);
    tick();

    // Streaming with 1-cycle latency.
    OUT_READY = 1'b1;
    got.delete();
    for (int i = 1; i <= 8; i++) begin
      send(DW'(i));
      check("stream_latency_valid", DW'(out_valid_a), DW'(1));
      check("stream_latency_data", out_data_a, DW'(i));
    end
    IN_VALID = 1'b0;
    tick(); tick();
    check("stream_count", DW'(got.size()), DW'(8));
    for (int i = 0; i < 8 && i < got.size(); i++) check("stream_order", got[i], DW'(i + 1));

    // Full-width payload passes unaltered.
    ones = '1;
    send(ones);
    check("wide_payload", out_data_a, ones);
    IN_VALID = 1'b0;
    tick();

    // Backpressure into the skid entry.
    got.delete();
    OUT_READY = 1'b0;
    send(DW'(8'hA));
    check("bp_occ1", DW'(occ_a), DW'(1));
    send(DW'(8'hB));
    check("bp_occ2", DW'(occ_a), DW'(2));
    check("bp_in_ready_low", DW'(in_ready_a), '0);
    send(DW'(8'hC));
    check("bp_c_held_off", DW'(occ_a), DW'(2));
    OUT_READY = 1'b1;
    tick(); tick();
    IN_VALID = 1'b0;
    tick(); tick();
    exp_list = '{DW'(8'hA), DW'(8'hB), DW'(8'hC)};
    check("bp_count", DW'(got.size()), DW'(3));
    for (int i = 0; i < 3 && i < got.size(); i++) check("bp_order", got[i], exp_list[i]);

    // Stall freezes a full stage and counts every held cycle.
    got.delete();
    OUT_READY = 1'b0;
    send(DW'(8'h55));
    IN_VALID = 1'b0;
    c0 = m_cnt_a;
    STALL = 1'b1; OUT_READY = 1'b1;
    tick(); tick(); tick();
    check("stall_hold_data", out_data_a, DW'(8'h55));
    check("stall_no_xfer", DW'(got.size()), '0);
    check("stall_count_plus3", DW'(cnt_a), DW'(c0 + 3));
    STALL = 1'b0;
    tick();
    check("stall_release_xfer", DW'(got.size()), DW'(1));
    if (got.size() > 0) check("stall_release_data", got[0], DW'(8'h55));
    check("stall_release_empty", DW'(occ_a), '0);

    // Flush of a skid-full stage under stall, with a new payload offered.
    got.delete();
    OUT_READY = 1'b0;
    send(DW'(8'h1));
    send(DW'(8'h2));
    FLUSH = 1'b1; STALL = 1'b1; IN_VALID = 1'b1; IN_DATA = DW'(8'h3);
    tick();
    FLUSH = 1'b0; STALL = 1'b0; IN_VALID = 1'b0;
    check("flush_out_valid", DW'(out_valid_a), '0);
    check("flush_occupancy", DW'(occ_a), '0);
    check("flush_zero_data", out_data_a, '0);
    OUT_READY = 1'b1;
    tick(); tick();
    check("flush_dropped", DW'(got.size()), '0);

    // Counter saturation on the 4-bit instance, from a fresh reset.
    RESET = 1'b1;
    tick();
    RESET = 1'b0;
    check("sat_reset_a", DW'(cnt_a), '0);
    check("sat_reset_b", DW'(cnt_b), '0);
    OUT_READY = 1'b0;
    send(DW'(8'h9));
    IN_VALID = 1'b0;
    for (int i = 0; i < 14; i++) tick();
    check("sat_b_at_14", DW'(cnt_b), DW'(14));
    for (int i = 0; i < 6; i++) tick();
    check("sat_b_held_15", DW'(cnt_b), DW'(15));
    check("sat_a_20", DW'(cnt_a), DW'(20));
    OUT_READY = 1'b1;
    tick(); tick();
    check("sat_b_after_drain", DW'(cnt_b), DW'(15));

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
